// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and counter widths used by both
// the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS_N = 8;
  localparam int CNT_W       = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// reset to RST_VAL so an idle line does not look like an edge after reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_Async;
      sync_q <= meta_q;
    end
  end

  assign o_Sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Define UART_RX_MAJORITY_EN to sample each bit as a 2-of-3 vote.
//
// state     | meaning
// IDLE      | waiting for the synchronised line to go low
// START_BIT | counting to the start-bit midpoint; high there means a glitch
// DATA_BITS | sampling 8 data bits LSB first, one per CLKS_PER_BIT cycles
// STOP_BIT  | sampling the stop bit; publish byte, pulse DV or frame error
// CLEANUP   | waiting for the line to return high (absorbs a break)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 48
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_PT_I = HALF + 1;
`else
  localparam int SAMPLE_PT_I = HALF;
`endif
  localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(SAMPLE_PT_I);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS_N - 1);

  logic rx_s;
  logic bit_smp;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic             active_q, active_d;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Async (i_Rx_Serial),
    .o_Sync  (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Last two rx_s values; together with the current one they span the vote window.
  logic [1:0] vote_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) vote_q <= 2'b11;
    else          vote_q <= {vote_q[0], rx_s};
  end

  assign bit_smp = maj3(vote_q[1], vote_q[0], rx_s);
`else
  assign bit_smp = rx_s;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d  = START_BIT;
          active_d = 1'b1;
        end
      end

      START_BIT: begin
        if (cnt_q == SAMPLE_PT) begin
          cnt_d = '0;
          if (!bit_smp) begin
            state_d = DATA_BITS;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA_BITS: begin
        if (cnt_q == LAST_CNT) begin
          shift_d[idx_q] = bit_smp;
          cnt_d          = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = STOP_BIT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP_BIT: begin
        if (cnt_q == LAST_CNT) begin
          // The byte is published even on a framing error so the consumer can inspect it.
          byte_d  = shift_q;
          dv_d    = bit_smp;
          ferr_d  = ~bit_smp;
          cnt_d   = '0;
          state_d = CLEANUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CLEANUP: begin
        if (rx_s) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// checked against an event-level model of when each byte should appear.
module tb_uart_rx;

  localparam int CPB  = 48;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 4 + HALF + 9 * CPB;
`else
  localparam int LAT = 3 + HALF + 9 * CPB;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx    = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
  logic       ferr;
  logic       active;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rbyte),
    .o_Rx_Frame_Err (ferr),
    .o_Rx_Active    (active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] b;
    logic       dv;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  excl_viol = 0;
  int  errors = 0;
  int  checks = 0;

  always @(negedge clk) begin
    if (dv === 1'b1 && ferr === 1'b1) excl_viol++;
    if (dv === 1'b1 || ferr === 1'b1) obs_q.push_back('{cyc, rbyte, dv});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_ev%0d_cycle", tag, i), 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
      chk($sformatf("%s_ev%0d_byte", tag, i), 32'(obs_q[i].b), 32'(exp_q[i].b));
      chk($sformatf("%s_ev%0d_isdv", tag, i), 32'(obs_q[i].dv), 32'(exp_q[i].dv));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Call right at a posedge. Returns k = first edge that samples the start bit low.
  // abort_bit >= 0 returns halfway through that data bit; glitch inverts one
  // cycle in the middle of each data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit,
                            input bit glitch, output int k);
    logic v;
    for (int p = 0; p < 10; p++) begin
      v = (p == 0) ? 1'b0 : (p == 9) ? stop : b[p-1];
      #1 rx = v;
      if (p == 0) k = cyc + 1;
      if (abort_bit >= 0 && p == abort_bit + 1) begin
        repeat (CPB / 2) @(posedge clk);
        return;
      end
      if (glitch && p >= 1 && p <= 8) begin
        repeat (CPB / 2 - 1) @(posedge clk);
        #1 rx = ~v;
        @(posedge clk);
        #1 rx = v;
        repeat (CPB - CPB / 2 - 1) @(posedge clk);
      end else begin
        repeat (CPB) @(posedge clk);
      end
    end
  endtask

  task automatic expect_frame(input int k, input logic [7:0] b, input logic stop);
    exp_q.push_back('{k + LAT, b, stop});
  endtask

  initial begin
    int         k, k0, k1, k2, gap;
    logic [7:0] rb;

    // Async reset with no clock edge yet.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dv", 32'(dv), 32'd0);
    chk("rst_byte", 32'(rbyte), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Clean byte.
    send_frame(8'hA5, 1'b1, -1, 1'b0, k);
    expect_frame(k, 8'hA5, 1'b1);
    #1 rx = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("clean_byte_held", 32'(rbyte), 32'hA5);
    check_events("clean");

    // Back-to-back bytes, no idle gap.
    @(posedge clk);
    send_frame(8'h00, 1'b1, -1, 1'b0, k0);
    send_frame(8'hFF, 1'b1, -1, 1'b0, k1);
    send_frame(8'h81, 1'b1, -1, 1'b0, k2);
    expect_frame(k0, 8'h00, 1'b1);
    expect_frame(k1, 8'hFF, 1'b1);
    expect_frame(k2, 8'h81, 1'b1);
    #1 rx = 1'b1;
    repeat (10) @(posedge clk);
    if (obs_q.size() == 3) begin
      chk("b2b_spacing01", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'(10 * CPB));
      chk("b2b_spacing12", 32'(obs_q[2].cyc - obs_q[1].cyc), 32'(10 * CPB));
    end
    check_events("b2b");

    // Random bytes with random short gaps (zero gap = back-to-back).
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, -1, 1'b0, k);
      expect_frame(k, rb, 1'b1);
      gap = $urandom_range(0, 20);
      if (gap > 0) begin
        #1 rx = 1'b1;
        repeat (gap) @(posedge clk);
      end
    end
    #1 rx = 1'b1;
    repeat (10) @(posedge clk);
    check_events("rand");

    // Bad stop bit followed by a long break.
    @(posedge clk);
    send_frame(8'h3C, 1'b0, -1, 1'b0, k);
    expect_frame(k, 8'h3C, 1'b0);
    repeat (2000) @(posedge clk);
    #1 chk("break_active_held", 32'(active), 32'd1);
    chk("break_byte", 32'(rbyte), 32'h3C);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("break_active_released", 32'(active), 32'd0);
    check_events("break");

    // Start-bit glitch: 10 low cycles on an idle line.
    @(posedge clk);
    #1 rx = 1'b0;
    k = cyc + 1;
    repeat (4) @(posedge clk);
    #1 chk("glitch_active_rise", 32'(active), 32'd1);
    repeat (6) @(posedge clk);
    #1 rx = 1'b1;
    repeat (HALF + 4 - 9) @(posedge clk);
    #1 chk("glitch_active_fall", 32'(active), 32'd0);
    repeat (CPB * 10) @(posedge clk);
    check_events("glitch");

    // Reset during bit 4 of 0x5A.
    @(posedge clk);
    send_frame(8'h5A, 1'b1, 4, 1'b0, k);
    #1 chk("midrst_active_before", 32'(active), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_dv", 32'(dv), 32'd0);
    chk("midrst_byte", 32'(rbyte), 32'd0);
    chk("midrst_ferr", 32'(ferr), 32'd0);
    chk("midrst_active", 32'(active), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (CPB * 10) @(posedge clk);
    check_events("midrst_discard");
    send_frame(8'h11, 1'b1, -1, 1'b0, k);
    expect_frame(k, 8'h11, 1'b1);
    #1 rx = 1'b1;
    repeat (10) @(posedge clk);
    check_events("midrst_after");

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted glitch in the middle of every data bit.
    @(posedge clk);
    send_frame(8'h0F, 1'b1, -1, 1'b1, k);
    expect_frame(k, 8'h0F, 1'b1);
    #1 rx = 1'b1;
    repeat (10) @(posedge clk);
    check_events("majority");
`endif

    chk("pulse_exclusive", 32'(excl_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
